rw_unit: RTL and testbench

Register-writeback stage of the SimpleRISC pipeline. It accepts retiring instructions from the memory-access stage over a valid/ready handshake and waits for late load data when needed. It selects the write-back value and destination, then drives the register-file write port `wr_adr`/`wr_data`/`is_wb` consumed by operand fetch. It is the writer side of the register-file write interface.

---
 rtl/simplerisc_pkg.sv | 20 ++
 rtl/rw_result_mux.sv | 27 ++
 rtl/rw_unit.sv | 135 +++++++++++++
 tb/tb_rw_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: control-bus bit positions, link register index
// and the write-back stage state encoding.
package simplerisc_pkg;

  localparam int CB_IS_ST   = 14;
  localparam int CB_IS_LD   = 13;
  localparam int CB_IS_RET  = 19;
  localparam int CB_IS_IMM  = 20;
  localparam int CB_IS_WB   = 21;
  localparam int CB_IS_CALL = 22;

  localparam logic [3:0] RA_REG = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_WRITE   = 2'd2
  } rw_state_t;

endpackage

// File: rtl/rw_result_mux.sv
// Combinational write-back source select: call link value, load data or ALU result.
module rw_result_mux
  import simplerisc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] ld_data,
  input  logic        is_call,
  input  logic        is_ld,
  output logic [3:0]  adr,
  output logic [31:0] data
);

  always_comb begin
    adr  = rd;
    data = alu_result;
    if (is_call) begin
      // Link address wraps naturally at 2^32.
      adr  = RA_REG;
      data = pc + 32'd4;
    end else if (is_ld) begin
      data = ld_data;
    end
  end

endmodule

// File: rtl/rw_unit.sv
// SimpleRISC register-writeback stage: accepts retiring instructions, waits for late
// load data and drives the register-file write port. Optional retire counter: RW_RETIRE_CNT_EN.
module rw_unit
  import simplerisc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ma_valid,
  output logic        ma_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic [23:0] control_bus_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] ld_data,
  input  logic        ld_valid,
  output logic [3:0]  wr_adr,
  output logic [31:0] wr_data,
  output logic        is_wb
`ifdef RW_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  rw_state_t   state_reg, state_next;
  logic [31:0] pc_reg, alu_reg;
  logic [3:0]  rd_reg;
  logic        cb_wb_reg, cb_ld_reg, cb_call_reg;
  logic [3:0]  wr_adr_reg;
  logic [31:0] wr_data_reg;
  logic        accept, load_wb, in_wait;
  logic [31:0] sel_pc, sel_alu, mux_data;
  logic [3:0]  sel_rd, mux_adr;
  logic        sel_call, sel_ld;

  assign ma_ready = reset && (state_reg != ST_WAIT_LD);
  assign accept   = ma_valid && ma_ready;
  assign in_wait  = (state_reg == ST_WAIT_LD);

  // A late load resolves from the latched instruction; otherwise from the live inputs.
  assign sel_pc   = in_wait ? pc_reg      : pc_in;
  assign sel_rd   = in_wait ? rd_reg      : instruction_in[25:22];
  assign sel_alu  = in_wait ? alu_reg     : alu_result_in;
  assign sel_call = in_wait ? cb_call_reg : control_bus_in[CB_IS_CALL];
  assign sel_ld   = in_wait ? cb_ld_reg   : control_bus_in[CB_IS_LD];

  rw_result_mux u_mux (
    .pc         (sel_pc),
    .rd         (sel_rd),
    .alu_result (sel_alu),
    .ld_data    (ld_data),
    .is_call    (sel_call),
    .is_ld      (sel_ld),
    .adr        (mux_adr),
    .data       (mux_data)
  );

  always_comb begin
    state_next = ST_IDLE;
    load_wb    = 1'b0;
    case (state_reg)
      ST_WAIT_LD: begin
        if (ld_valid) begin
          state_next = ST_WRITE;
          load_wb    = 1'b1;
        end else begin
          state_next = ST_WAIT_LD;
        end
      end
      default: begin
        if (accept) begin
          if (control_bus_in[CB_IS_LD] && !ld_valid) begin
            state_next = ST_WAIT_LD;
          end else begin
            state_next = ST_WRITE;
            load_wb    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      alu_reg     <= '0;
      rd_reg      <= '0;
      cb_wb_reg   <= 1'b0;
      cb_ld_reg   <= 1'b0;
      cb_call_reg <= 1'b0;
      wr_adr_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pc_reg      <= pc_in;
        alu_reg     <= alu_result_in;
        rd_reg      <= instruction_in[25:22];
        cb_wb_reg   <= control_bus_in[CB_IS_WB];
        cb_ld_reg   <= control_bus_in[CB_IS_LD];
        cb_call_reg <= control_bus_in[CB_IS_CALL];
      end
      if (load_wb) begin
        wr_adr_reg  <= mux_adr;
        wr_data_reg <= mux_data;
      end
    end
  end

  assign wr_adr  = wr_adr_reg;
  assign wr_data = wr_data_reg;
  assign is_wb   = (state_reg == ST_WRITE) && cb_wb_reg;

`ifdef RW_RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  // Counts every instruction passing through WRITE, including non-writing ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_cnt_reg <= '0;
    end else if (state_reg == ST_WRITE) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_count = retire_cnt_reg;
`endif

  // Instruction and control-bus fields consumed by other stages only.
  logic unused_ok;
  assign unused_ok = ^{instruction_in[31:26], instruction_in[21:0],
                       control_bus_in[23], control_bus_in[20:14], control_bus_in[12:0]};

endmodule

// File: tb/tb_rw_unit.sv
// Scoreboard bench for rw_unit: stimulus pushes expected register writes, a negedge
// monitor pops and compares each is_wb pulse.
module tb_rw_unit;

  logic        clk;
  logic        reset;
  logic        ma_valid;
  logic        ma_ready;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic [23:0] control_bus_in;
  logic [31:0] alu_result_in;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic [3:0]  wr_adr;
  logic [31:0] wr_data;
  logic        is_wb;
`ifdef RW_RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic [31:0] rc_before;
`endif

  localparam logic [23:0] CB_ADD  = 24'h200000;
  localparam logic [23:0] CB_LD   = 24'h202000;
  localparam logic [23:0] CB_ST   = 24'h004000;
  localparam logic [23:0] CB_CALL = 24'h600000;

  typedef struct {
    int          cyc;
    logic [3:0]  adr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rw_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ma_valid       (ma_valid),
    .ma_ready       (ma_ready),
    .pc_in          (pc_in),
    .instruction_in (instruction_in),
    .control_bus_in (control_bus_in),
    .alu_result_in  (alu_result_in),
    .ld_data        (ld_data),
    .ld_valid       (ld_valid),
    .wr_adr         (wr_adr),
    .wr_data        (wr_data),
    .is_wb          (is_wb)
`ifdef RW_RETIRE_CNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per observed write, compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (is_wb === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: got adr=%0d data=0x%08h expected no write (cycle %0d)",
                 wr_adr, wr_data, cyc);
      end else begin
        e = sb_q.pop_front();
        $display("wb cycle=%0d adr=%0d data=0x%08h", cyc, wr_adr, wr_data);
        check("wb_cycle", cyc, e.cyc);
        check("wb_adr", {28'd0, wr_adr}, {28'd0, e.adr});
        check("wb_data", wr_data, e.data);
      end
    end
  end

  task automatic push_exp(input logic [3:0] adr, input logic [31:0] data);
    exp_t e;
    e.cyc  = cyc + 1;
    e.adr  = adr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Present one instruction for one cycle; caller has made sure ma_ready is high.
  task automatic issue(input logic [31:0] pc, input logic [3:0] rd, input logic [23:0] cb,
                       input logic [31:0] alu, input logic lv, input logic [31:0] ld,
                       input logic exp_wb, input logic [3:0] eadr, input logic [31:0] edata);
    ma_valid       = 1'b1;
    pc_in          = pc;
    instruction_in = {6'd0, rd, 22'd0};
    control_bus_in = cb;
    alu_result_in  = alu;
    ld_valid       = lv;
    ld_data        = ld;
    @(posedge clk);
    #1;
    if (exp_wb) push_exp(eadr, edata);
  endtask

  task automatic idle(input int n);
    ma_valid = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    ma_valid = 1'b0;
    pc_in = '0;
    instruction_in = '0;
    control_bus_in = '0;
    alu_result_in = '0;
    ld_data = '0;
    ld_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ma_ready}, 32'd0);
    check("rst_adr", {28'd0, wr_adr}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_wb", {31'd0, is_wb}, 32'd0);
`ifdef RW_RETIRE_CNT_EN
    check("rst_count", retire_count, 32'd0);
`endif
    reset = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, ma_ready}, 32'd1);
    idle(2);

    // ADD r3 = 0x55, then held outputs and no second pulse
    issue(32'h40, 4'd3, CB_ADD, 32'h0000_0055, 1'b0, 32'h0, 1'b1, 4'd3, 32'h55);
    idle(2);
    check("hold_adr", {28'd0, wr_adr}, 32'd3);
    check("hold_data", wr_data, 32'h55);
    check("hold_wb", {31'd0, is_wb}, 32'd0);

    // Late load r7: three stall cycles, data arrives in the third
    issue(32'h44, 4'd7, CB_LD, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    ma_valid = 1'b0;
    check("ld_stall1", {31'd0, ma_ready}, 32'd0);
    @(posedge clk); #1;
    check("ld_stall2", {31'd0, ma_ready}, 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    check("ld_stall3", {31'd0, ma_ready}, 32'd0);
    @(posedge clk); #1;
    push_exp(4'd7, 32'hDEAD_BEEF);
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    check("ld_ready_back", {31'd0, ma_ready}, 32'd1);
    idle(1);

    // Same-cycle load r9
    issue(32'h48, 4'd9, CB_LD, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 4'd9, 32'h1234_5678);
    idle(1);

    // Calls, including link wrap
    issue(32'h0000_0100, 4'd2, CB_CALL, 32'hAAAA, 1'b0, 32'h0, 1'b1, 4'd15, 32'h104);
    idle(1);
    issue(32'hFFFF_FFFC, 4'd2, CB_CALL, 32'hAAAA, 1'b0, 32'h0, 1'b1, 4'd15, 32'h0);
    idle(1);

    // Back-to-back ST, ADD r1, ADD r2
`ifdef RW_RETIRE_CNT_EN
    rc_before = retire_count;
`endif
    issue(32'h50, 4'd4, CB_ST, 32'h99, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    check("b2b_ready1", {31'd0, ma_ready}, 32'd1);
    issue(32'h54, 4'd1, CB_ADD, 32'h11, 1'b0, 32'h0, 1'b1, 4'd1, 32'h11);
    check("b2b_ready2", {31'd0, ma_ready}, 32'd1);
    issue(32'h58, 4'd2, CB_ADD, 32'h22, 1'b0, 32'h0, 1'b1, 4'd2, 32'h22);
    check("b2b_ready3", {31'd0, ma_ready}, 32'd1);
    idle(2);
`ifdef RW_RETIRE_CNT_EN
    check("b2b_count", retire_count, rc_before + 32'd3);
`endif

    // Reset while waiting for a load, then a stray ld_valid
    issue(32'h60, 4'd5, CB_LD, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    ma_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("wrst_ready_low", {31'd0, ma_ready}, 32'd0);
    @(posedge clk); #1;
    check("wrst_adr", {28'd0, wr_adr}, 32'd0);
    check("wrst_data", wr_data, 32'd0);
    ld_valid = 1'b1;
    ld_data  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("wrst_ready_rel", {31'd0, ma_ready}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    check("wrst_wb", {31'd0, is_wb}, 32'd0);
    check("wrst_adr2", {28'd0, wr_adr}, 32'd0);
    check("wrst_data2", wr_data, 32'd0);
    check("wrst_ready", {31'd0, ma_ready}, 32'd1);
`ifdef RW_RETIRE_CNT_EN
    check("wrst_count", retire_count, 32'd0);
`endif
    idle(2);

`ifdef RW_RETIRE_CNT_EN
    // Counter wrap
    force dut.retire_cnt_reg = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retire_cnt_reg;
    issue(32'h70, 4'd6, CB_ADD, 32'h66, 1'b0, 32'h0, 1'b1, 4'd6, 32'h66);
    ma_valid = 1'b0;
    @(posedge clk); #1;
    check("count_wrap", retire_count, 32'd0);
    idle(1);
`endif

    idle(3);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
